// File: rtl/modulo_varredura_teclado_pkg.sv
// -----------------------------------------------------------------------------
// modulo_varredura_teclado_pkg
// Shared definitions for the 4x4 keypad scanner: FSM state encoding, keypad
// dimensions, the idle row pattern and small helpers for decoding a row
// pattern that has exactly one key pulled low.
// -----------------------------------------------------------------------------
package modulo_varredura_teclado_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int ROW_W    = $clog2(NUM_ROWS);
    localparam int COL_W    = $clog2(NUM_COLS);

    // Rows are active-low: all ones means no key pulls a row down.
    localparam logic [NUM_ROWS-1:0] ROW_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // True when exactly one row bit is low; two or more low bits can be a
    // ghost image of a multi-key press and are never treated as a key.
    function automatic logic single_low(input logic [NUM_ROWS-1:0] rows);
        int n_low;
        n_low = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows[i]) n_low++;
        end
        return (n_low == 1);
    endfunction

    // Index of the low row bit; only meaningful when single_low() holds.
    function automatic logic [ROW_W-1:0] low_index(input logic [NUM_ROWS-1:0] rows);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows[i]) idx = ROW_W'(i);
        end
        return idx;
    endfunction

    // Row pattern produced by a single key on row idx.
    function automatic logic [NUM_ROWS-1:0] row_mask(input logic [ROW_W-1:0] idx);
        logic [NUM_ROWS-1:0] m;
        m      = ROW_IDLE;
        m[idx] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/modulo_sincronizador_2ff.sv
// -----------------------------------------------------------------------------
// modulo_sincronizador_2ff
// Two-flop synchronizer for a bus of independent, slowly changing bits.
//   clk   : destination clock
//   clr   : synchronous active-high reset, loads RESET_VALUE into both stages
//   din   : asynchronous input bus
//   dout  : synchronized output bus (two cycles of latency)
// -----------------------------------------------------------------------------
module modulo_sincronizador_2ff #(
    parameter int                 WIDTH       = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments let both stages sample their inputs at the
    // same edge; blocking ones would collapse the chain into a single flop.
    always_ff @(posedge clk) begin
        if (clr) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/modulo_varredura_teclado.sv
// -----------------------------------------------------------------------------
// modulo_varredura_teclado
// 4x4 matrix keypad scanner with press/release debouncing.
//   clk       : single clock
//   clr       : synchronous active-high reset
//   row_in    : keypad rows, active-low, asynchronous (bit 0 = top row)
//   col_out   : column drive, one-hot active-low (bit 0 = left column)
//   key_code  : last accepted key, row*4 + col
//   key_valid : one-cycle pulse when a press is accepted
//   key_held  : high from acceptance until the release is confirmed
// Rows are evaluated once per column slot (every SCAN_DIV cycles). A single
// low row freezes the column and must repeat for DEBOUNCE_CNT samples before
// it is accepted; release needs DEBOUNCE_CNT consecutive idle samples.
// -----------------------------------------------------------------------------
module modulo_varredura_teclado
    import modulo_varredura_teclado_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [NUM_ROWS-1:0]    row_in,
    output logic [NUM_COLS-1:0]    col_out,
    output logic [ROW_W+COL_W-1:0] key_code,
    output logic                   key_valid,
    output logic                   key_held
);

    localparam int               CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_TARGET = 4'(DEBOUNCE_CNT);

    logic [NUM_ROWS-1:0] rs;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         slot_q, slot_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [3:0]               deb_q, deb_d;
    logic [ROW_W+COL_W-1:0]   key_code_q, key_code_d;
    logic                     key_valid_q, key_valid_d;
    logic                     key_held_q, key_held_d;

    logic       sample;
    logic       accept;
    logic [3:0] deb_inc;

    modulo_sincronizador_2ff #(
        .WIDTH       (NUM_ROWS),
        .RESET_VALUE (ROW_IDLE)
    ) u_sinc_rows (
        .clk  (clk),
        .clr  (clr),
        .din  (row_in),
        .dout (rs)
    );

    assign sample  = (slot_q == SLOT_LAST);
    assign deb_inc = deb_q + 4'd1;

    // State and datapath register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= SCAN;
            slot_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            deb_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            col_q       <= col_d;
            row_q       <= row_d;
            deb_q       <= deb_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    // Next-state logic. Everything is evaluated against rs before the column
    // is advanced, so an accepted code always names the column that was driven.
    always_comb begin
        // NOTE: every variable gets a default first so no path can leave one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        slot_d      = sample ? '0 : slot_q + CNT_W'(1);
        col_d       = col_q;
        row_d       = row_q;
        deb_d       = deb_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        accept      = 1'b0;

        if (sample) begin
            unique case (state_q)
                SCAN: begin
                    if (single_low(rs)) begin
                        // The detecting sample is the first matching sample.
                        row_d = low_index(rs);
                        deb_d = 4'd1;
                        if (DEB_TARGET <= 4'd1) accept  = 1'b1;
                        else                    state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (rs == row_mask(row_q)) begin
                        deb_d = deb_inc;
                        if (deb_inc >= DEB_TARGET) accept = 1'b1;
                    end else begin
                        state_d = SCAN;
                        deb_d   = '0;
                        col_d   = col_q + COL_W'(1);
                    end
                end
                HELD: begin
                    // Only consecutive idle samples count toward release, so
                    // any other key seen here merely restarts the count.
                    if (rs == ROW_IDLE) begin
                        deb_d = deb_inc;
                        if (deb_inc >= DEB_TARGET) begin
                            state_d    = SCAN;
                            deb_d      = '0;
                            key_held_d = 1'b0;
                            col_d      = col_q + COL_W'(1);
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    deb_d   = '0;
                end
            endcase

            if (accept) begin
                state_d     = HELD;
                deb_d       = '0;
                key_code_d  = {row_d, col_q};
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
            end
        end
    end

    // Outputs: the column drive decodes straight from the registered index,
    // so exactly one column is low in every cycle, reset included.
    always_comb begin
        col_out        = '1;
        col_out[col_q] = 1'b0;
        key_code       = key_code_q;
        key_valid      = key_valid_q;
        key_held       = key_held_q;
    end

endmodule

// File: tb/tb_modulo_varredura_teclado.sv
// -----------------------------------------------------------------------------
// tb_modulo_varredura_teclado
// Self-checking bench for the keypad scanner with SCAN_DIV=4, DEBOUNCE_CNT=2.
// A small keypad model turns the set of pressed keys and the driven column into
// row levels. Expected key codes are queued when a press is made and compared
// whenever key_valid pulses. Cycle numbers count clock edges since clr fell;
// column slots end on every fourth edge.
// -----------------------------------------------------------------------------
module tb_modulo_varredura_teclado;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 2;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] row_in = 4'hF;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    always #5 clk = ~clk;

    modulo_varredura_teclado #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    typedef struct {
        logic [3:0] rows;
        logic [3:0] exp_col;
        logic       exp_valid;
        logic       exp_held;
    } vec_t;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [15:0] keys = '0;
    logic [3:0] exp_q[$];
    logic       prev_valid = 1'b0;
    vec_t       idle_vec[40];

    // Key index r*4+c shorts row r to column c.
    function automatic logic [3:0] keypad_rows(input logic [15:0] k, input logic [3:0] cols);
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++) begin
            for (int ci = 0; ci < 4; ci++) begin
                if (k[ri*4+ci] && !cols[ci]) r[ri] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: outputs are inspected on the falling edge, then the keypad
    // model updates the rows for the column now being driven.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (key_valid === 1'b1) begin
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() > 0) check("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            else                  check("unexpected_valid", {31'd0, key_valid}, 32'd0);
        end
        prev_valid = key_valid;
        row_in = keypad_rows(keys, col_out);
    endtask

    task automatic set_key(input int idx, input logic v);
        keys[idx] = v;
        row_in = keypad_rows(keys, col_out);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_pulse(input string name, input int budget);
        int n;
        n = 0;
        while (key_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (key_valid !== 1'b1) check(name, {31'd0, key_valid}, 32'd1);
    endtask

    task automatic wait_held_low(input string name, input int budget);
        int n;
        n = 0;
        while (key_held !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        if (key_held !== 1'b0) check(name, {31'd0, key_held}, 32'd0);
    endtask

    task automatic do_reset(input logic check_state);
        @(negedge clk);
        clr    = 1'b1;
        keys   = '0;
        row_in = 4'hF;
        repeat (3) @(negedge clk);
        if (check_state) begin
            check("rst_col", {28'd0, col_out}, 32'hE);
            check("rst_code", {28'd0, key_code}, 32'h0);
            check("rst_valid", {31'd0, key_valid}, 32'd0);
            check("rst_held", {31'd0, key_held}, 32'd0);
        end
        clr        = 1'b0;
        cyc        = 0;
        prev_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] one;
        one = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            idle_vec[i].rows      = 4'hF;
            idle_vec[i].exp_col   = ~(one << ((i / 4) % 4));
            idle_vec[i].exp_valid = 1'b0;
            idle_vec[i].exp_held  = 1'b0;
        end

        // Reset state, then idle scanning from the table.
        do_reset(1'b1);
        for (int i = 0; i < 40; i++) begin
            row_in = idle_vec[i].rows;
            check("idle_col", {28'd0, col_out}, {28'd0, idle_vec[i].exp_col});
            check("idle_valid", {31'd0, key_valid}, {31'd0, idle_vec[i].exp_valid});
            check("idle_held", {31'd0, key_held}, {31'd0, idle_vec[i].exp_held});
            step();
        end

        // Clean press of key 6 (row 1, column 2): seen at the cycle-12 sample,
        // accepted one sample later.
        do_reset(1'b0);
        set_key(6, 1'b1);
        exp_q.push_back(4'd6);
        wait_pulse("press_timeout", 40);
        check("press_cycle", cyc, 32'd16);
        check("press_held", {31'd0, key_held}, 32'd1);
        check("press_col", {28'd0, col_out}, 32'hB);
        step();
        check("valid_one_cycle", {31'd0, key_valid}, 32'd0);
        run_to(28);
        check("held_frozen_col", {28'd0, col_out}, 32'hB);
        check("held_level", {31'd0, key_held}, 32'd1);

        // Release: two idle samples (cycles 32 and 36) confirm it.
        set_key(6, 1'b0);
        run_to(35);
        check("release_pending_held", {31'd0, key_held}, 32'd1);
        check("release_pending_col", {28'd0, col_out}, 32'hB);
        step();
        check("release_held", {31'd0, key_held}, 32'd0);
        check("release_col", {28'd0, col_out}, 32'h7);
        check("release_code_kept", {28'd0, key_code}, 32'd6);

        // Re-press of the same key: column 2 comes round again at cycle 48.
        set_key(6, 1'b1);
        exp_q.push_back(4'd6);
        wait_pulse("repress_timeout", 40);
        check("repress_cycle", cyc, 32'd56);
        set_key(6, 1'b0);
        wait_held_low("repress_release_timeout", 40);

        // Bounce: row low for a single sample only.
        do_reset(1'b0);
        run_to(8);
        set_key(6, 1'b1);
        run_to(12);
        set_key(6, 1'b0);
        run_to(15);
        check("bounce_debounce_col", {28'd0, col_out}, 32'hB);
        step();
        check("bounce_abort_col", {28'd0, col_out}, 32'h7);
        check("bounce_held", {31'd0, key_held}, 32'd0);
        run_to(20);
        check("bounce_resume_col", {28'd0, col_out}, 32'hE);
        check("bounce_code", {28'd0, key_code}, 32'd0);

        // Multi-key: rows 1 and 3 on column 0 give rows=0101, never a key.
        do_reset(1'b0);
        set_key(4, 1'b1);
        set_key(12, 1'b1);
        check("ghost_rows", {28'd0, row_in}, 32'h5);
        run_to(4);
        check("ghost_scan_col", {28'd0, col_out}, 32'hD);
        run_to(20);
        check("ghost_scan_col2", {28'd0, col_out}, 32'hD);
        check("ghost_held", {31'd0, key_held}, 32'd0);
        set_key(4, 1'b0);
        set_key(12, 1'b0);

        // A second key during HELD must not produce a pulse or a release.
        set_key(6, 1'b1);
        exp_q.push_back(4'd6);
        wait_pulse("second_timeout", 40);
        set_key(10, 1'b1);
        repeat (12) step();
        check("second_held", {31'd0, key_held}, 32'd1);
        check("second_col", {28'd0, col_out}, 32'hB);
        set_key(6, 1'b0);
        repeat (12) step();
        check("second_only_held", {31'd0, key_held}, 32'd1);
        check("second_code", {28'd0, key_code}, 32'd6);
        set_key(10, 1'b0);
        wait_held_low("second_release_timeout", 40);

        // Reset while HELD: everything clears on the next cycle and scanning
        // restarts from column 0, so the still-pressed key is found again.
        set_key(6, 1'b1);
        exp_q.push_back(4'd6);
        wait_pulse("rst_held_timeout", 40);
        step();
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        check("rst_held_code", {28'd0, key_code}, 32'd0);
        check("rst_held_held", {31'd0, key_held}, 32'd0);
        check("rst_held_col", {28'd0, col_out}, 32'hE);
        check("rst_held_valid", {31'd0, key_valid}, 32'd0);
        cyc        = 0;
        prev_valid = 1'b0;
        row_in     = keypad_rows(keys, col_out);
        exp_q.push_back(4'd6);
        wait_pulse("rst_resume_timeout", 40);
        check("rst_resume_cycle", cyc, 32'd16);
        set_key(6, 1'b0);
        wait_held_low("rst_resume_release_timeout", 40);

        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
